// File: rtl/mips_boot_loader.sv
// Boot loader: receives a byte stream over valid/ready, packs bytes into
// 32-bit words, writes them to instruction memory, then releases the core.
// Ports:
//   clk, reset (async active-low)
//   start, word_count             load request and word count
//   byte_valid, byte_data         byte stream in
//   byte_ready                    loader accepts a byte this cycle
//   imem_we, imem_addr, imem_wdata instruction-memory write port
//   cpu_reset                     active-low reset to the core
//   busy, done, err, checksum     status
module mips_boot_loader #(
    parameter int ADDR_W     = 10,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [ADDR_W:0] MAX_N = {1'b1, {ADDR_W{1'b0}}};

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ADDR_W:0] r_n;
    logic [ADDR_W:0] r_cnt;
    logic [1:0]      r_idx;
    logic [31:0]     r_word;
    logic [31:0]     w_pack;
    logic [1:0]      w_lane;
    logic            w_hs;
    logic            w_ready;
    logic            w_busy;
    logic            w_we;
    logic            w_done;
    logic            w_err;

    assign w_hs   = byte_valid & byte_ready & (r_state == S_RECV);
    // Big-endian puts the first byte in the top lane.
    assign w_lane = BIG_ENDIAN ? ~r_idx : r_idx;

    always_comb begin
        w_pack = r_word;
        w_pack[{w_lane, 3'b000} +: 8] = byte_data;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (word_count == '0)
                        w_state_nxt = S_DONE;
                    else if (word_count > MAX_N)
                        w_state_nxt = S_ERROR;
                    else
                        w_state_nxt = S_RECV;
                end
            end
            S_RECV: begin
                if (w_hs && r_idx == 2'd3)
                    w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (r_cnt + 1'b1 == r_n)
                    w_state_nxt = S_DONE;
                else
                    w_state_nxt = S_RECV;
            end
            S_DONE:  w_state_nxt = S_DONE;
            S_ERROR: w_state_nxt = S_ERROR;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state, so registered outputs line up
    // with the state they describe.
    always_comb begin
        w_ready = (w_state_nxt == S_RECV);
        w_busy  = (w_state_nxt == S_RECV) || (w_state_nxt == S_WRITE);
        w_we    = (w_state_nxt == S_WRITE);
        w_done  = (w_state_nxt == S_DONE);
        w_err   = (w_state_nxt == S_ERROR);
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_n        <= '0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_word     <= '0;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            checksum   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            byte_ready <= w_ready;
            imem_we    <= w_we;
            busy       <= w_busy;
            done       <= w_done;
            cpu_reset  <= w_done;
            err        <= w_err;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n       <= word_count;
                        r_cnt     <= '0;
                        r_idx     <= '0;
                        r_word    <= '0;
                        imem_addr <= '0;
                    end
                end
                S_RECV: begin
                    if (w_hs) begin
                        r_word <= w_pack;
                        r_idx  <= r_idx + 2'd1;
                        if (r_idx == 2'd3)
                            imem_wdata <= w_pack;
                    end
                end
                S_WRITE: begin
                    checksum <= checksum + imem_wdata;
                    r_cnt    <= r_cnt + 1'b1;
                    // Hold the last address so imem_addr never wraps.
                    if (w_state_nxt == S_RECV)
                        imem_addr <= imem_addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
